// File: rtl/rng_share_arbiter.sv
// Round-robin arbiter sharing one LFSR RNG among NUM_REQ requesters.
// Also owns seeding: seed load, warmup discard shifts, then grant service.
module rng_share_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned IDX_W         = 2,
   parameter int unsigned WARMUP_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rand_valid,
   output logic [31:0]        rand_data,
   output logic [IDX_W-1:0]   rand_id,
   input  logic [31:0]        cfg_seed,
   input  logic               cfg_seed_wr,
   output logic               cfg_busy,
   output logic               rng_enable,
   output logic               rng_seed_load,
   output logic [31:0]        rng_seed,
   input  logic [31:0]        rng_random
);

   localparam int unsigned CNT_W = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES + 1);
   localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP_CYCLES);

   typedef enum logic [1:0] {
      S_SEED,
      S_WARM,
      S_RUN
   } state_t;

   localparam state_t RST_STATE = (WARMUP_CYCLES == 0) ? S_RUN : S_WARM;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   rr, rr_nxt, pick, idx;
   logic [NUM_REQ-1:0] elig;
   logic               found;
   logic               grant;

   // A requester still holding req during its own gnt cycle is skipped.
   always_comb begin
      elig  = req & ~gnt;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'((32'(rr) + k) % NUM_REQ);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      rr_nxt = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rng_enable    = 1'b0;
      rng_seed_load = 1'b0;
      cfg_busy      = 1'b0;
      grant         = 1'b0;
      case (state)
         S_SEED: begin
            rng_seed_load = 1'b1;
            cfg_busy      = 1'b1;
            if (WARMUP_CYCLES == 0) begin
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_WARM;
               cnt_nxt   = WARM_INIT;
            end
         end
         S_WARM: begin
            rng_enable = 1'b1;
            cfg_busy   = 1'b1;
            cnt_nxt    = cnt - 1'b1;
            if (cnt <= CNT_W'(1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (found && !cfg_seed_wr) begin
               grant      = 1'b1;
               rng_enable = 1'b1;
            end
         end
         default: state_nxt = RST_STATE;
      endcase
      if (cfg_seed_wr) state_nxt = S_SEED;
      // Strobes to the rng stay quiet for the whole reset assertion.
      if (!rst_n) begin
         rng_enable    = 1'b0;
         rng_seed_load = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST_STATE;
         cnt        <= WARM_INIT;
         rr         <= '0;
         gnt        <= '0;
         rand_valid <= 1'b0;
         rand_data  <= '0;
         rand_id    <= '0;
         rng_seed   <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         gnt        <= '0;
         rand_valid <= grant;
         if (cfg_seed_wr) rng_seed <= cfg_seed;
         if (grant) begin
            gnt[pick] <= 1'b1;
            rand_id   <= pick;
            rand_data <= rng_random;
            rr        <= rr_nxt;
         end
      end
   end

endmodule
